// File: rtl/circ_buff_write_many128.sv
// circ_buff_write_many128
//   Writer end of a circular slot buffer. Accepts a valid/ready stream of
//   DATA_WIDTH-bit words and packs each packet into the next free slot of a
//   shared buffer RAM (slot base = slot index * slot size). On completion a
//   one-cycle commit pulse is raised with the slot's word count, and wr_ptr
//   advances so the reader can drain the slot.
//
// Ports
//   ap_clk      clock, rising edge
//   ap_rst      asynchronous active-high reset
//   slot_words  words per slot, sampled when a slot is opened
//   s_data/s_valid/s_last/s_ready  input stream
//   rd_ptr      reader's next slot to read
//   mem_we/mem_addr/mem_din        buffer RAM write port (1-cycle latency)
//   wr_ptr      next slot to be written
//   commit      one-cycle pulse, slot completed
//   commit_len  word count of the last committed slot
//   buf_full    no free slot (one slot is always kept empty)
//   overflow    sticky, packet words were dropped after a slot filled
module circ_buff_write_many128 #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [LEN_WIDTH-1:0]  slot_words,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [IDX_WIDTH-1:0]  rd_ptr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [IDX_WIDTH-1:0]  wr_ptr,
  output logic                  commit,
  output logic [LEN_WIDTH-1:0]  commit_len,
  output logic                  buf_full,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LEN_WIDTH-1:0]    off_q, off_d;
  logic [IDX_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LEN_WIDTH-1:0]    commit_len_q, commit_len_d;
  logic                    overflow_q, overflow_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic                    s_ready_q, s_ready_d;
  logic                    commit_q, commit_d;

  logic [IDX_WIDTH-1:0]    wr_next;
  logic                    accept;

  assign wr_next  = (wr_ptr_q == IDX_WIDTH'(NUM_SLOTS - 1)) ? '0
                                                            : wr_ptr_q + IDX_WIDTH'(1);
  assign buf_full = (wr_next == rd_ptr);
  assign accept   = s_valid & s_ready_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    base_d       = base_q;
    off_d        = off_q;
    wr_ptr_d     = wr_ptr_q;
    commit_len_d = commit_len_q;
    overflow_d   = overflow_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;

    case (state_q)
      IDLE: begin
        if (!buf_full && (slot_words != '0)) begin
          state_d = WRITE;
          len_d   = slot_words;
          // Operands are widened to the full address width so the product
          // of slot index and slot size is exact.
          base_d  = ADDR_WIDTH'(wr_ptr_q) * ADDR_WIDTH'(slot_words);
          off_d   = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = base_q + ADDR_WIDTH'(off_q);
          mem_din_d  = s_data;
          off_d      = off_q + LEN_WIDTH'(1);
          if (s_last) begin
            state_d      = COMMIT;
            commit_len_d = off_q + LEN_WIDTH'(1);
          end else if (off_q == len_q - LEN_WIDTH'(1)) begin
            // Slot filled mid-packet; commit_len is only updated on the way
            // into COMMIT so it keeps its previous value until the pulse.
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        overflow_d = 1'b1;
        if (accept && s_last) begin
          state_d      = COMMIT;
          commit_len_d = len_q;
        end
      end
      COMMIT: begin
        wr_ptr_d = wr_next;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == WRITE) || (state_d == DRAIN);
    commit_d  = (state_d == COMMIT);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      base_q       <= '0;
      off_q        <= '0;
      wr_ptr_q     <= '0;
      commit_len_q <= '0;
      overflow_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      s_ready_q    <= 1'b0;
      commit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      base_q       <= base_d;
      off_q        <= off_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_len_q <= commit_len_d;
      overflow_q   <= overflow_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      s_ready_q    <= s_ready_d;
      commit_q     <= commit_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign commit     = commit_q;
  assign commit_len = commit_len_q;
  assign wr_ptr     = wr_ptr_q;
  assign overflow   = overflow_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_circ_buff_write_many128.sv
// Bench for circ_buff_write_many128: an 8-slot instance (dut0) exercises the
// main packet/overflow/full/reset behaviour; a 256-slot instance (dut1) is
// walked to slot 255 to exercise the widest slot base arithmetic.
module tb_circ_buff_write_many128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        [2];
  logic [15:0]  slot_words [2];
  logic [127:0] s_data     [2];
  logic         s_valid    [2];
  logic         s_last     [2];
  logic         s_ready    [2];
  logic [7:0]   rd_ptr     [2];
  logic         mem_we     [2];
  logic [23:0]  mem_addr   [2];
  logic [127:0] mem_din    [2];
  logic [7:0]   wr_ptr     [2];
  logic         commit     [2];
  logic [15:0]  commit_len [2];
  logic         buf_full   [2];
  logic         overflow   [2];

  circ_buff_write_many128 #(.NUM_SLOTS(8)) dut0 (
    .ap_clk(clk), .ap_rst(rst[0]), .slot_words(slot_words[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .rd_ptr(rd_ptr[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .wr_ptr(wr_ptr[0]),
    .commit(commit[0]), .commit_len(commit_len[0]), .buf_full(buf_full[0]),
    .overflow(overflow[0])
  );

  circ_buff_write_many128 #(.NUM_SLOTS(256)) dut1 (
    .ap_clk(clk), .ap_rst(rst[1]), .slot_words(slot_words[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .rd_ptr(rd_ptr[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .wr_ptr(wr_ptr[1]),
    .commit(commit[1]), .commit_len(commit_len[1]), .buf_full(buf_full[1]),
    .overflow(overflow[1])
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model state: slot pointer and sticky overflow per instance.
  int m_wp   [2];
  bit m_ovf  [2];
  int nslots [2];

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_next(input int k);
    return (m_wp[k] == nslots[k] - 1) ? 0 : m_wp[k] + 1;
  endfunction

  task automatic check_reset_outputs(input int k);
    check_eq("rst_s_ready",    s_ready[k],    0);
    check_eq("rst_mem_we",     mem_we[k],     0);
    check_eq("rst_commit",     commit[k],     0);
    check_eq("rst_overflow",   overflow[k],   0);
    check_eq("rst_wr_ptr",     wr_ptr[k],     0);
    check_eq("rst_commit_len", commit_len[k], 0);
    check_eq("rst_mem_addr",   mem_addr[k],   0);
    check_eq("rst_mem_din",    mem_din[k],    0);
    check_eq("rst_buf_full",   buf_full[k],   rd_ptr[k] == 8'(m_next(k)));
  endtask

  // Sends one n-word packet with random valid gaps into a slot of the current
  // slot_words size and checks every RAM write, the commit pulse and pointers.
  task automatic send_pkt(input int k, input int n);
    int      len, sent, exp_len;
    bit      pend, done;
    logic [23:0]  p_addr;
    logic [127:0] p_data;
    longint  base;
    #1;
    len     = int'(slot_words[k]);
    base    = longint'(m_wp[k]) * longint'(len);
    exp_len = (n < len) ? n : len;
    sent    = 0;
    pend    = 1'b0;
    done    = 1'b0;
    p_addr  = '0;
    p_data  = '0;
    check_eq("buf_full_pre", buf_full[k], rd_ptr[k] == 8'(m_next(k)));
    for (int cyc = 0; cyc < 60 + 8 * n && !done; cyc++) begin
      @(posedge clk); #1;
      check_eq("mem_we", mem_we[k], pend);
      if (pend) begin
        check_eq("mem_addr", mem_addr[k], p_addr);
        check_eq("mem_din",  mem_din[k],  p_data);
      end
      pend = 1'b0;
      if (commit[k]) begin
        check_eq("commit_len",   commit_len[k], exp_len);
        check_eq("wr_ptr_at_commit", wr_ptr[k], m_wp[k]);
        check_eq("words_sent",   sent, n);
        done = 1'b1;
      end
      s_valid[k] = 1'b0;
      s_last[k]  = 1'b0;
      if (!done && sent < n && $urandom_range(0, 3) != 0) begin
        s_valid[k] = 1'b1;
        s_data[k]  = {$urandom, $urandom, $urandom, $urandom};
        s_last[k]  = (sent == n - 1);
        if (s_ready[k]) begin
          if (sent < len) begin
            pend   = 1'b1;
            p_addr = 24'((base + longint'(sent)) % 64'd16777216);
            p_data = s_data[k];
          end
          sent++;
        end
      end
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
    if (!done) check_eq("commit_timeout", 0, 1);
    if (n > len) m_ovf[k] = 1'b1;
    m_wp[k] = m_next(k);
    @(posedge clk); #1;
    check_eq("wr_ptr_after", wr_ptr[k], m_wp[k]);
    check_eq("commit_single", commit[k], 0);
    check_eq("mem_we_idle",   mem_we[k], 0);
    check_eq("overflow",      overflow[k], m_ovf[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    nslots[0] = 8;
    nslots[1] = 256;
    for (int k = 0; k < 2; k++) begin
      rst[k]        = 1'b1;
      slot_words[k] = '0;
      s_data[k]     = '0;
      s_valid[k]    = 1'b0;
      s_last[k]     = 1'b0;
      rd_ptr[k]     = '0;
      m_wp[k]       = 0;
      m_ovf[k]      = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Basic 4-word slot, packet fills it exactly.
    slot_words[0] = 16'd4;
    send_pkt(0, 4);

    // 16-word slots up to slot 5, then a short packet at base 80.
    slot_words[0] = 16'd16;
    for (int i = 0; i < 4; i++) send_pkt(0, int'($urandom_range(1, 16)));
    send_pkt(0, 3);

    // Packet longer than the slot: tail words dropped, overflow set.
    slot_words[0] = 16'd2;
    send_pkt(0, 5);

    // Ring full at wr_ptr=7 with rd_ptr=0: writer must stall.
    check_eq("wr_ptr_before_full", wr_ptr[0], 7);
    check_eq("buf_full", buf_full[0], 1);
    s_valid[0] = 1'b1;
    s_last[0]  = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("stall_s_ready", s_ready[0], 0);
      check_eq("stall_mem_we",  mem_we[0],  0);
    end
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    rd_ptr[0]  = 8'd1;
    send_pkt(0, 2);
    check_eq("wr_ptr_wrap", wr_ptr[0], 0);

    // Zero slot size keeps the writer idle.
    slot_words[0] = 16'd0;
    s_valid[0]    = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("zero_len_s_ready", s_ready[0], 0);
      check_eq("zero_len_mem_we",  mem_we[0],  0);
    end
    s_valid[0] = 1'b0;

    // Random slot sizes, packet lengths and reader positions (never full).
    for (int i = 0; i < 14; i++) begin
      rd_ptr[0]     = 8'((m_wp[0] + int'($urandom_range(2, 8))) % 8);
      slot_words[0] = 16'($urandom_range(1, 6));
      send_pkt(0, int'($urandom_range(1, 9)));
    end

    // Reset in the middle of a slot after two accepted words.
    rd_ptr[0]     = 8'((m_wp[0] + 4) % 8);
    slot_words[0] = 16'd4;
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 2; cyc++) begin
      @(posedge clk); #1;
      s_valid[0] = 1'b1;
      s_last[0]  = 1'b0;
      s_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      if (s_ready[0]) acc++;
    end
    check_eq("mid_write_accepts", acc, 2);
    @(posedge clk); #1;
    s_valid[0] = 1'b0;
    #2;
    rst[0]   = 1'b1;
    m_wp[0]  = 0;
    m_ovf[0] = 1'b0;
    #1;
    check_reset_outputs(0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_no_commit", commit[0], 0);
    end
    rd_ptr[0] = '0;
    rst[0]    = 1'b0;
    send_pkt(0, 3);

    // 256-slot instance: walk to slot 255, then the largest slot size.
    slot_words[1] = 16'd1;
    for (int i = 0; i < 255; i++) send_pkt(1, 1);
    check_eq("dut1_wr_ptr_255", wr_ptr[1], 255);
    check_eq("dut1_full_255", buf_full[1], 1);
    rd_ptr[1]     = 8'd1;
    slot_words[1] = 16'hFFFF;
    send_pkt(1, 3);
    check_eq("dut1_wrap", wr_ptr[1], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
